// File: rtl/bram_port_arbiter_if.sv
// Requester-side bus for one port of the shared Block RAM arbiter.
// Handshake: req with addr/wstrb/wdata held stable until gnt; a transfer completes
// in the cycle where req && gnt; reads answer with rvalid/rdata exactly one cycle later.
interface bram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic [3:0]            wstrb;
  logic [31:0]           wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [31:0]           rdata;

  modport master (output req, addr, wstrb, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, wstrb, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/bram_port_arbiter.sv
// Two-port arbiter onto one Block RAM: m0 has priority, m1 is guaranteed a grant
// after MAX_WAIT contested cycles. Read data is steered back one cycle after grant.
module bram_port_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clka,
  input  logic                  rstn,
  bram_port_arbiter_if.slave    m0,
  bram_port_arbiter_if.slave    m1,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  output logic [31:0]           ram_dina,
  output logic [3:0]            ram_wea,
  input  logic [31:0]           ram_doutb,
  output logic [3:0]            dbg_wait_cnt,
  output logic [1:0]            dbg_rd_pend
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic [1:0] rd_pend, rd_pend_nxt;
  logic       force_m1, gnt0, gnt1;

  always_comb begin
    force_m1     = (wait_cnt == MAX_W);
    gnt1         = rstn && m1.req && (!m0.req || force_m1);
    gnt0         = rstn && m0.req && !gnt1;
    wait_cnt_nxt = 4'd0;
    if (m1.req && !gnt1)
      wait_cnt_nxt = (wait_cnt >= MAX_W) ? MAX_W : wait_cnt + 4'd1;
    rd_pend_nxt  = {gnt1 && (m1.wstrb == 4'd0), gnt0 && (m0.wstrb == 4'd0)};
  end

  always_ff @(posedge clka) begin
    if (!rstn) begin
      wait_cnt <= 4'd0;
      rd_pend  <= 2'b00;
    end else begin
      wait_cnt <= wait_cnt_nxt;
      rd_pend  <= rd_pend_nxt;
    end
  end

  // Address/data follow m0 unless m1 holds the grant; only wea must be exact.
  always_comb begin
    ram_addra = gnt1 ? m1.addr  : m0.addr;
    ram_dina  = gnt1 ? m1.wdata : m0.wdata;
    ram_wea   = 4'd0;
    if (gnt0)      ram_wea = m0.wstrb;
    else if (gnt1) ram_wea = m1.wstrb;
  end

  assign ram_addrb    = ram_addra;
  assign m0.gnt       = gnt0;
  assign m1.gnt       = gnt1;
  assign m0.rvalid    = rd_pend[0];
  assign m1.rvalid    = rd_pend[1];
  assign m0.rdata     = rd_pend[0] ? ram_doutb : 32'd0;
  assign m1.rdata     = rd_pend[1] ? ram_doutb : 32'd0;
  assign dbg_wait_cnt = wait_cnt;
  assign dbg_rd_pend  = rd_pend;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: directed scenarios plus random traffic
// against a word-array memory model and a read-response queue.
module tb_bram_port_arbiter;
  localparam int AW       = 12;
  localparam int MAX_WAIT = 4;

  logic          clka = 1'b0;
  logic          rstn;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [31:0]   ram_dina, ram_doutb;
  logic [3:0]    ram_wea, dbg_wait_cnt;
  logic [1:0]    dbg_rd_pend;

  bram_port_arbiter_if #(.ADDR_WIDTH(AW)) m0_if ();
  bram_port_arbiter_if #(.ADDR_WIDTH(AW)) m1_if ();

  bram_port_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clka(clka), .rstn(rstn), .m0(m0_if.slave), .m1(m1_if.slave),
    .ram_addra(ram_addra), .ram_addrb(ram_addrb), .ram_dina(ram_dina),
    .ram_wea(ram_wea), .ram_doutb(ram_doutb),
    .dbg_wait_cnt(dbg_wait_cnt), .dbg_rd_pend(dbg_rd_pend)
  );

  // ---------------- clock / reset ----------------
  always #5 clka = ~clka;

  // Block RAM stand-in: byte-write port A, registered read port B
  logic [31:0] ram_mem [0:(1<<AW)-1];
  always @(posedge clka) begin
    for (int b = 0; b < 4; b++)
      if (ram_wea[b]) ram_mem[ram_addra][b*8 +: 8] <= ram_dina[b*8 +: 8];
    ram_doutb <= ram_mem[ram_addrb];
  end

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] ref_mem [0:(1<<AW)-1];
  logic [32:0] exp_q[$];      // {port, data} of reads granted last cycle
  int          lost    = 0;   // consecutive cycles m1 requested without winning
  int          m1_run  = 0;   // observed m1 waiting time
  int          dut_m1_gnts = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input bit rst, input bit r0, input logic [AW-1:0] a0,
                       input logic [3:0] s0, input logic [31:0] d0,
                       input bit r1, input logic [AW-1:0] a1,
                       input logic [3:0] s1, input logic [31:0] d1,
                       output bit g0, output bit g1);
    logic [32:0] e;
    logic [3:0]  exp_wea;
    rstn = rst;
    m0_if.req = r0; m0_if.addr = a0; m0_if.wstrb = s0; m0_if.wdata = d0;
    m1_if.req = r1; m1_if.addr = a1; m1_if.wstrb = s1; m1_if.wdata = d1;
    #1;
    // m1 wins when alone, or when it has already lost MAX_WAIT contested cycles
    g1 = rst && r1 && (!r0 || lost == MAX_WAIT);
    g0 = rst && r0 && !g1;
    exp_wea = g0 ? s0 : (g1 ? s1 : 4'd0);
    check_eq("m0_gnt", 64'(m0_if.gnt), 64'(g0));
    check_eq("m1_gnt", 64'(m1_if.gnt), 64'(g1));
    check_eq("ram_wea", 64'(ram_wea), 64'(exp_wea));
    check_eq("wait_cnt", 64'(dbg_wait_cnt), 64'(lost));
    if (g0 || g1) begin
      check_eq("ram_addra", 64'(ram_addra), 64'(g1 ? a1 : a0));
      check_eq("ram_addrb", 64'(ram_addrb), 64'(g1 ? a1 : a0));
      check_eq("ram_dina", 64'(ram_dina), 64'(g1 ? d1 : d0));
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("m0_rvalid", 64'(m0_if.rvalid), 64'(!e[32]));
      check_eq("m1_rvalid", 64'(m1_if.rvalid), 64'(e[32]));
      check_eq(e[32] ? "m1_rdata" : "m0_rdata",
               64'(e[32] ? m1_if.rdata : m0_if.rdata), 64'(e[31:0]));
      check_eq(e[32] ? "m0_rdata_idle" : "m1_rdata_idle",
               64'(e[32] ? m0_if.rdata : m1_if.rdata), 64'd0);
    end else begin
      check_eq("rvalid_idle", 64'({m1_if.rvalid, m0_if.rvalid}), 64'd0);
      check_eq("rdata_idle", {m1_if.rdata, m0_if.rdata}, 64'd0);
    end
    if (m1_if.gnt) begin
      dut_m1_gnts++;
      check_eq("m1_wait_bound", 64'(m1_run <= MAX_WAIT), 64'd1);
      m1_run = 0;
    end else if (r1 && rst) begin
      m1_run++;
    end else begin
      m1_run = 0;
    end
    @(posedge clka);
    // reference model update at the clock edge
    if (!rst) begin
      exp_q.delete();
      lost = 0;
    end else begin
      if (g0 || g1) begin
        logic [AW-1:0] a;
        logic [3:0]    s;
        logic [31:0]   d;
        a = g1 ? a1 : a0; s = g1 ? s1 : s0; d = g1 ? d1 : d0;
        if (s == 4'd0) exp_q.push_back({g1, ref_mem[a]});
        for (int b = 0; b < 4; b++)
          if (s[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
      end
      if (r1 && !g1) lost = (lost >= MAX_WAIT) ? MAX_WAIT : lost + 1;
      else           lost = 0;
    end
    @(negedge clka);
  endtask

  task automatic idle(input int n);
    bit g0, g1;
    for (int i = 0; i < n; i++) cycle(1, 0, '0, '0, '0, 0, '0, '0, '0, g0, g1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit g0, g1;
    bit          b0, b1;
    logic [AW-1:0] ra0, ra1;
    logic [3:0]    rs0, rs1;
    logic [31:0]   rd0, rd1;
    for (int i = 0; i < (1<<AW); i++) begin
      ram_mem[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    rstn = 1'b0;
    m0_if.req = 0; m0_if.addr = '0; m0_if.wstrb = '0; m0_if.wdata = '0;
    m1_if.req = 0; m1_if.addr = '0; m1_if.wstrb = '0; m1_if.wdata = '0;
    repeat (2) @(posedge clka);
    @(negedge clka);

    // reset held with both requesting: no grants, no writes
    for (int i = 0; i < 3; i++)
      cycle(0, 1, 12'h001, 4'hF, 32'h1, 1, 12'h002, 4'hF, 32'h2, g0, g1);
    cycle(1, 1, 12'h005, 4'h0, 32'h0, 0, '0, '0, '0, g0, g1);
    check_eq("post_reset_m0_first", 64'(g0), 64'd1);
    idle(1);

    // m0 full write then read back
    cycle(1, 1, 12'h010, 4'hF, 32'hDEADBEEF, 0, '0, '0, '0, g0, g1);
    cycle(1, 1, 12'h010, 4'h0, 32'h0, 0, '0, '0, '0, g0, g1);
    check_eq("m0_rd_valid", 64'(m0_if.rvalid), 64'd1);
    check_eq("m0_rd_data", 64'(m0_if.rdata), 64'hDEADBEEF);
    check_eq("m0_rd_m1_quiet", 64'(m1_if.rvalid), 64'd0);
    idle(1);

    // m1 partial write over existing word
    cycle(1, 0, '0, '0, '0, 1, 12'h020, 4'hF, 32'h11223344, g0, g1);
    cycle(1, 0, '0, '0, '0, 1, 12'h020, 4'b0001, 32'h000000AA, g0, g1);
    cycle(1, 0, '0, '0, '0, 1, 12'h020, 4'h0, 32'h0, g0, g1);
    check_eq("m1_partial_data", 64'(m1_if.rdata), 64'h112233AA);
    check_eq("m1_partial_m0_quiet", 64'(m0_if.rvalid), 64'd0);
    idle(1);

    // continuous contention: m1 expected every (MAX_WAIT+1)th cycle
    dut_m1_gnts = 0;
    for (int i = 0; i < 20; i++)
      cycle(1, 1, 12'(i), 4'h0, '0, 1, 12'h020, 4'h0, '0, g0, g1);
    check_eq("contention_m1_grants", 64'(dut_m1_gnts), 64'd4);
    idle(1);

    // pipelined reads 0..3 after seeding distinct values
    for (int i = 0; i < 4; i++)
      cycle(1, 1, 12'(i), 4'hF, 32'hA5A50000 + 32'(i), 0, '0, '0, '0, g0, g1);
    for (int i = 0; i < 4; i++)
      cycle(1, 1, 12'(i), 4'h0, '0, 0, '0, '0, '0, g0, g1);
    check_eq("pipe_last_data", 64'(m0_if.rdata), 64'hA5A50003);
    idle(1);

    // reset right after an m1 read grant, with m1 having built up wait
    cycle(1, 1, 12'h030, 4'h0, '0, 1, 12'h020, 4'h0, '0, g0, g1);
    cycle(1, 0, '0, '0, '0, 1, 12'h020, 4'h0, '0, g0, g1);
    cycle(0, 1, 12'h030, 4'h0, '0, 1, 12'h021, 4'h0, '0, g0, g1);
    check_eq("rst_m1_rvalid_cleared", 64'(m1_if.rvalid), 64'd0);
    check_eq("rst_wait_cnt_cleared", 64'(dbg_wait_cnt), 64'd0);
    idle(1);

    // random traffic; attributes held until granted
    b0 = 0; b1 = 0;
    ra0 = '0; ra1 = '0; rs0 = '0; rs1 = '0; rd0 = '0; rd1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!b0 && $urandom_range(0, 3) != 0) begin
        b0 = 1; ra0 = 12'($urandom_range(0, 15));
        rs0 = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'h0;
        rd0 = $urandom;
      end
      if (!b1 && $urandom_range(0, 2) != 0) begin
        b1 = 1; ra1 = 12'($urandom_range(0, 15));
        rs1 = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'h0;
        rd1 = $urandom;
      end
      cycle(1, b0, ra0, rs0, rd0, b1, ra1, rs1, rd1, g0, g1);
      if (g0) b0 = 0;
      if (g1) b1 = 0;
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
